// File: rtl/twiddle_mult.sv
// rtl/twiddle_mult.sv - radix-2^2 SDF twiddle stage: frame counter, table address, 3-cycle complex multiply
module twiddle_mult #(
    parameter int WIDTH = 16,
    parameter int LOG_N = 6,
    parameter int LOG_M = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic [LOG_N-1:0] tw_addr,
    input  logic [WIDTH-1:0] tw_re,
    input  logic [WIDTH-1:0] tw_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im
);

    localparam int SW = 2 * WIDTH + 1;
    localparam logic signed [SW-1:0] RND     = SW'(2 ** (WIDTH - 2));
    localparam logic signed [SW-1:0] SAT_MAX = SW'(2 ** (WIDTH - 1) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-(2 ** (WIDTH - 1)));

    // Frame position and stage-1 registers
    logic [LOG_M-1:0] r_cnt;
    logic [LOG_N-1:0] r_tw_addr;
    logic             r_s1_en;
    logic             r_s1_byp;
    logic [WIDTH-1:0] r_s1_re;
    logic [WIDTH-1:0] r_s1_im;

    // Stage-2 registers: partial products plus the raw sample for bypass
    logic                      r_s2_en;
    logic                      r_s2_byp;
    logic [WIDTH-1:0]          r_s2_re;
    logic [WIDTH-1:0]          r_s2_im;
    logic signed [2*WIDTH-1:0] r_ac;
    logic signed [2*WIDTH-1:0] r_bd;
    logic signed [2*WIDTH-1:0] r_ad;
    logic signed [2*WIDTH-1:0] r_bc;

    // Stage-3 (output) registers
    logic             r_do_en;
    logic [WIDTH-1:0] r_do_re;
    logic [WIDTH-1:0] r_do_im;

    // Address generation: the two top counter bits pick the quarter-frame
    // multiplier in bit-reversed order (0,2,1,3), the rest give the index.
    logic [1:0]       w_sel;
    logic [LOG_N-1:0] w_num;
    logic [LOG_N-1:0] w_addr;

    assign w_sel  = {r_cnt[LOG_M-2], r_cnt[LOG_M-1]};
    assign w_num  = LOG_N'(r_cnt[LOG_M-3:0]) << (LOG_N - LOG_M);
    assign w_addr = w_num * LOG_N'(w_sel);

    // Full-precision butterfly sums, one bit wider than the products
    logic signed [SW-1:0] w_sum_re;
    logic signed [SW-1:0] w_sum_im;
    logic [WIDTH-1:0]     w_mul_re;
    logic [WIDTH-1:0]     w_mul_im;

    assign w_sum_re = SW'(r_ac) - SW'(r_bd);
    assign w_sum_im = SW'(r_ad) + SW'(r_bc);

    // Round half-up back to Q1.15, then clamp to the representable range
    function automatic logic [WIDTH-1:0] round_sat(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] t;
        t = (s + RND) >>> (WIDTH - 1);
        if (t > SAT_MAX) begin
            round_sat = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (t < SAT_MIN) begin
            round_sat = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            round_sat = t[WIDTH-1:0];
        end
    endfunction

    assign w_mul_re = round_sat(w_sum_re);
    assign w_mul_im = round_sat(w_sum_im);

    // Stage 1: accept the sample, advance the frame counter, issue the table address
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_tw_addr <= '0;
            r_s1_en   <= 1'b0;
            r_s1_byp  <= 1'b0;
            r_s1_re   <= '0;
            r_s1_im   <= '0;
        end else begin
            r_s1_en <= di_en;
            if (di_en) begin
                r_cnt     <= r_cnt + LOG_M'(1);
                r_tw_addr <= w_addr;
                r_s1_byp  <= (w_addr == '0);
                r_s1_re   <= di_re;
                r_s1_im   <= di_im;
            end
        end
    end

    // Stage 2: four signed products against the twiddle returned for r_tw_addr
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s2_en  <= 1'b0;
            r_s2_byp <= 1'b0;
            r_s2_re  <= '0;
            r_s2_im  <= '0;
            r_ac     <= '0;
            r_bd     <= '0;
            r_ad     <= '0;
            r_bc     <= '0;
        end else begin
            r_s2_en <= r_s1_en;
            if (r_s1_en) begin
                r_s2_byp <= r_s1_byp;
                r_s2_re  <= r_s1_re;
                r_s2_im  <= r_s1_im;
                r_ac     <= $signed(r_s1_re) * $signed(tw_re);
                r_bd     <= $signed(r_s1_im) * $signed(tw_im);
                r_ad     <= $signed(r_s1_re) * $signed(tw_im);
                r_bc     <= $signed(r_s1_im) * $signed(tw_re);
            end
        end
    end

    // Stage 3: pick multiplied or bypassed sample; data holds across gaps
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_do_en <= 1'b0;
            r_do_re <= '0;
            r_do_im <= '0;
        end else begin
            r_do_en <= r_s2_en;
            if (r_s2_en) begin
                r_do_re <= r_s2_byp ? r_s2_re : w_mul_re;
                r_do_im <= r_s2_byp ? r_s2_im : w_mul_im;
            end
        end
    end

    assign tw_addr = r_tw_addr;
    assign do_en   = r_do_en;
    assign do_re   = r_do_re;
    assign do_im   = r_do_im;

endmodule

// File: tb/tb_twiddle_mult.sv
// tb/tb_twiddle_mult.sv - self-checking bench for twiddle_mult
module tb_twiddle_mult;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        di_en = 1'b0;
    logic [15:0] di_re = '0;
    logic [15:0] di_im = '0;
    logic [5:0]  tw_addr;
    logic [15:0] tw_re;
    logic [15:0] tw_im;
    logic        do_en;
    logic [15:0] do_re;
    logic [15:0] do_im;

    logic [15:0] tbl_re [64];
    logic [15:0] tbl_im [64];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int          pos;
    bit          q_en [$];
    logic [15:0] q_re [$];
    logic [15:0] q_im [$];
    bit          exp_en;
    logic [15:0] exp_re;
    logic [15:0] exp_im;
    int          exp_addr;

    twiddle_mult #(.WIDTH(16), .LOG_N(6), .LOG_M(6)) dut (
        .clock   (clock),
        .reset   (reset),
        .di_en   (di_en),
        .di_re   (di_re),
        .di_im   (di_im),
        .tw_addr (tw_addr),
        .tw_re   (tw_re),
        .tw_im   (tw_im),
        .do_en   (do_en),
        .do_re   (do_re),
        .do_im   (do_im)
    );

    assign tw_re = tbl_re[tw_addr];
    assign tw_im = tbl_im[tw_addr];

    always #5 clock = ~clock;

    // Table address from frame position: quarter q uses multiplier 0,2,1,3
    function automatic int ref_addr(input int p);
        int n;
        int m;
        n = p % 16;
        case (p / 16)
            0:       m = 0;
            1:       m = 2;
            2:       m = 1;
            default: m = 3;
        endcase
        return (n * m) % 64;
    endfunction

    // Complex product in Q1.15 with round-half-up and saturation
    function automatic logic [31:0] ref_mult(input logic [15:0] a, input logic [15:0] b,
                                             input logic [15:0] c, input logic [15:0] d);
        longint sa, sb, sc, sd, re, im;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sc = longint'($signed(c));
        sd = longint'($signed(d));
        re = sa * sc - sb * sd;
        im = sa * sd + sb * sc;
        re = (re + 16384) >>> 15;
        im = (im + 16384) >>> 15;
        if (re > 32767) re = 32767;
        if (re < -32768) re = -32768;
        if (im > 32767) im = 32767;
        if (im < -32768) im = -32768;
        return {re[15:0], im[15:0]};
    endfunction

    function automatic logic [15:0] rnd_word();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic model_reset();
        pos = 0;
        q_en.delete(); q_re.delete(); q_im.delete();
        repeat (2) begin
            q_en.push_back(1'b0); q_re.push_back(16'h0); q_im.push_back(16'h0);
        end
        exp_en   = 1'b0;
        exp_re   = 16'h0;
        exp_im   = 16'h0;
        exp_addr = 0;
    endtask

    // One clock: drive at negedge, advance the model, return 1 unit after the posedge
    task automatic drive(input bit en, input logic [15:0] re, input logic [15:0] im);
        int          a;
        logic [31:0] o;
        o = 32'h0;
        @(negedge clock);
        di_en = en; di_re = re; di_im = im;
        if (en) begin
            a        = ref_addr(pos);
            exp_addr = a;
            pos      = (pos + 1) % 64;
            o        = (a == 0) ? {re, im} : ref_mult(re, im, tbl_re[a], tbl_im[a]);
        end
        q_en.push_back(en); q_re.push_back(o[31:16]); q_im.push_back(o[15:0]);
        @(posedge clock);
        #1;
        exp_en = q_en.pop_front();
        o[31:16] = q_re.pop_front();
        o[15:0]  = q_im.pop_front();
        if (exp_en) begin
            exp_re = o[31:16];
            exp_im = o[15:0];
        end
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b0;
        di_en = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        n_cmp++; if (do_en !== 1'b0)    begin n_err++; $display("FAIL reset_do_en: got %b want 0", do_en); end
        n_cmp++; if (do_re !== 16'h0)   begin n_err++; $display("FAIL reset_do_re: got %h want 0000", do_re); end
        n_cmp++; if (do_im !== 16'h0)   begin n_err++; $display("FAIL reset_do_im: got %h want 0000", do_im); end
        n_cmp++; if (tw_addr !== 6'd0)  begin n_err++; $display("FAIL reset_tw_addr: got %0d want 0", tw_addr); end
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 30; i++) drive(1'b1, 16'h4000 | 16'($urandom_range(1, 255)), 16'($urandom));
        #2;
        reset = 1'b0;
        di_en = 1'b0;
        #1;
        n_cmp++; if (do_en !== 1'b0)   begin n_err++; $display("FAIL midreset_do_en: got %b want 0", do_en); end
        n_cmp++; if (do_re !== 16'h0)  begin n_err++; $display("FAIL midreset_do_re: got %h want 0000", do_re); end
        n_cmp++; if (do_im !== 16'h0)  begin n_err++; $display("FAIL midreset_do_im: got %h want 0000", do_im); end
        n_cmp++; if (tw_addr !== 6'd0) begin n_err++; $display("FAIL midreset_tw_addr: got %0d want 0", tw_addr); end
        repeat (2) begin
            @(posedge clock);
            #1;
            n_cmp++; if (do_en !== 1'b0 || do_re !== 16'h0 || tw_addr !== 6'd0)
                begin n_err++; $display("FAIL reset_hold: got en=%b re=%h addr=%0d want 0", do_en, do_re, tw_addr); end
        end
        @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_addr_seq();
        pulse_reset();
        for (int i = 0; i < 67; i++) begin
            drive(i < 65, 16'($urandom), 16'($urandom));
            n_cmp++; if (tw_addr !== 6'(exp_addr))
                begin n_err++; $display("FAIL addr_seq[%0d]: got %0d want %0d", i, tw_addr, exp_addr); end
            n_cmp++; if (do_en !== exp_en || do_re !== exp_re || do_im !== exp_im)
                begin n_err++; $display("FAIL addr_seq_do[%0d]: got %b %h %h want %b %h %h", i, do_en, do_re, do_im, exp_en, exp_re, exp_im); end
            if (i == 63) begin
                n_cmp++; if (tw_addr !== 6'd45) begin n_err++; $display("FAIL addr_wrap_max: got %0d want 45", tw_addr); end
            end
            if (i == 64) begin
                n_cmp++; if (tw_addr !== 6'd0) begin n_err++; $display("FAIL addr_sample65: got %0d want 0", tw_addr); end
            end
        end
    endtask

    task automatic test_multiply();
        pulse_reset();
        for (int k = 0; k < 27; k++) begin
            drive(k < 25, 16'h4000, 16'h0000);
            if (k == 24) begin
                n_cmp++; if (tw_addr !== 6'd16) begin n_err++; $display("FAIL mult_addr: got %0d want 16", tw_addr); end
            end
            if (k == 25) begin
                n_cmp++; if (do_im === 16'hC000) begin n_err++; $display("FAIL mult_early: got %h one edge early, want other value", do_im); end
            end
        end
        n_cmp++; if (do_en !== 1'b1 || do_re !== 16'h0000 || do_im !== 16'hC000)
            begin n_err++; $display("FAIL mult_value: got %b %h %h want 1 0000 c000", do_en, do_re, do_im); end
    endtask

    task automatic test_bypass();
        pulse_reset();
        drive(1'b1, 16'h1234, 16'h8000);
        drive(1'b0, 16'h0, 16'h0);
        drive(1'b0, 16'h0, 16'h0);
        n_cmp++; if (do_en !== 1'b1 || do_re !== 16'h1234 || do_im !== 16'h8000)
            begin n_err++; $display("FAIL bypass: got %b %h %h want 1 1234 8000", do_en, do_re, do_im); end
        drive(1'b0, 16'h0, 16'h0);
        n_cmp++; if (do_en !== 1'b0 || do_re !== 16'h1234 || do_im !== 16'h8000)
            begin n_err++; $display("FAIL bypass_hold: got %b %h %h want 0 1234 8000", do_en, do_re, do_im); end
    endtask

    task automatic test_saturation();
        pulse_reset();
        for (int k = 0; k < 28; k++) drive(1'b1, 16'($urandom), 16'($urandom));
        drive(1'b1, 16'h8000, 16'h8000);
        n_cmp++; if (tw_addr !== 6'd24) begin n_err++; $display("FAIL sat_addr: got %0d want 24", tw_addr); end
        drive(1'b0, 16'h0, 16'h0);
        drive(1'b0, 16'h0, 16'h0);
        n_cmp++; if (do_en !== 1'b1 || do_re !== 16'h0000 || do_im !== 16'h7FFF)
            begin n_err++; $display("FAIL saturation: got %b %h %h want 1 0000 7fff", do_en, do_re, do_im); end
    endtask

    task automatic test_gaps_reset();
        bit pat [9] = '{1, 0, 0, 1, 1, 0, 1, 0, 0};
        pulse_reset();
        for (int i = 0; i < 9; i++) begin
            drive(pat[i], 16'($urandom), 16'($urandom));
            if (i >= 2) begin
                n_cmp++; if (do_en !== pat[i-2])
                    begin n_err++; $display("FAIL gap_do_en[%0d]: got %b want %b", i, do_en, pat[i-2]); end
            end
        end
        for (int i = 0; i < 14; i++) drive(1'b1, 16'($urandom), 16'($urandom));
        n_cmp++; if (tw_addr !== 6'd2) begin n_err++; $display("FAIL gap_cnt: got %0d want 2", tw_addr); end
        for (int i = 0; i < 20; i++) drive(1'b1, 16'($urandom), 16'($urandom));
        pulse_reset();
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 16'($urandom), 16'($urandom));
            if (i == 0) begin
                n_cmp++; if (tw_addr !== 6'd0) begin n_err++; $display("FAIL post_reset_addr: got %0d want 0", tw_addr); end
            end
            if (i < 2) begin
                n_cmp++; if (do_en !== 1'b0 || do_re !== 16'h0 || do_im !== 16'h0)
                    begin n_err++; $display("FAIL post_reset_stale[%0d]: got %b %h %h want 0 0000 0000", i, do_en, do_re, do_im); end
            end else begin
                n_cmp++; if (do_en !== exp_en || do_re !== exp_re || do_im !== exp_im)
                    begin n_err++; $display("FAIL post_reset_do[%0d]: got %b %h %h want %b %h %h", i, do_en, do_re, do_im, exp_en, exp_re, exp_im); end
            end
        end
        n_cmp++; if (tw_addr !== 6'd2) begin n_err++; $display("FAIL post_reset_cnt: got %0d want 2", tw_addr); end
    endtask

    task automatic test_random();
        pulse_reset();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, rnd_word(), rnd_word());
            n_cmp++; if (tw_addr !== 6'(exp_addr))
                begin n_err++; $display("FAIL rand_addr[%0d]: got %0d want %0d", i, tw_addr, exp_addr); end
            n_cmp++; if (do_en !== exp_en || do_re !== exp_re || do_im !== exp_im)
                begin n_err++; $display("FAIL rand_do[%0d]: got %b %h %h want %b %h %h", i, do_en, do_re, do_im, exp_en, exp_re, exp_im); end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            tbl_re[i] = rnd_word();
            tbl_im[i] = rnd_word();
        end
        tbl_re[0]  = 16'h0000; tbl_im[0]  = 16'h0000;
        tbl_re[16] = 16'h0000; tbl_im[16] = 16'h8000;
        tbl_re[24] = 16'hA57E; tbl_im[24] = 16'hA57E;
        model_reset();
        test_reset();
        test_addr_seq();
        test_multiply();
        test_bypass();
        test_saturation();
        test_gaps_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
